// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register for the MIPS-style CPU.
// It carries the PC, a packed multi-word payload, the destination and rd
// register numbers, the exception state and a valid bit across one stage boundary.
// Edge priority is flush, then stall, then load.
// An exception detected in the feeding stage is merged at load time.
// An upstream exception always wins over the local one.
// A saturating counter records the number of cycles in which a valid
// instruction was held by a stall.
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_DATA = 4,
    parameter int          REG_W    = 5,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int          CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [31:0]                  pc_in,
    input  logic                         bd_in,
    input  logic [NUM_DATA*DATA_W-1:0]   data_in,
    input  logic [REG_W-1:0]             a3_in,
    input  logic [REG_W-1:0]             rd_in,
    input  logic                         exc_in,
    input  logic [EXC_W-1:0]             exc_code_in,
    input  logic                         loc_exc,
    input  logic [EXC_W-1:0]             loc_code,
    output logic                         valid_out,
    output logic [31:0]                  pc_out,
    output logic                         bd_out,
    output logic [NUM_DATA*DATA_W-1:0]   data_out,
    output logic [REG_W-1:0]             a3_out,
    output logic [REG_W-1:0]             rd_out,
    output logic                         exc_out,
    output logic [EXC_W-1:0]             exc_code_out,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int PAY_W = NUM_DATA * DATA_W;

    logic                r_valid;
    logic [31:0]         r_pc;
    logic                r_bd;
    logic [PAY_W-1:0]    r_data;
    logic [REG_W-1:0]    r_a3;
    logic [REG_W-1:0]    r_rd;
    logic                r_exc;
    logic [EXC_W-1:0]    r_exc_code;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_loc_hit;
    logic                w_exc_merged;
    logic [EXC_W-1:0]    w_code_merged;
    logic [REG_W-1:0]    w_a3_next;
    logic                w_cnt_inc;

    // Merge upstream and local exceptions; a local one only counts for a valid instruction
    always_comb begin
        w_loc_hit     = loc_exc & valid_in;
        w_exc_merged  = exc_in | w_loc_hit;
        w_code_merged = {EXC_W{1'b0}};
        w_a3_next     = a3_in;
        if (exc_in) begin
            w_code_merged = exc_code_in;
        end else if (w_loc_hit) begin
            w_code_merged = loc_code;
        end else begin
            w_code_merged = {EXC_W{1'b0}};
        end
        // A faulting instruction must not write back or forward its result
        if (w_exc_merged) begin
            w_a3_next = {REG_W{1'b0}};
        end else begin
            w_a3_next = a3_in;
        end
    end

    // Count only held valid instructions, and stop at all-ones instead of wrapping
    always_comb begin
        w_cnt_inc = 1'b0;
        if (stall && !flush && r_valid && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_cnt_inc = 1'b1;
        end else begin
            w_cnt_inc = 1'b0;
        end
    end

    // Stage contents: flush inserts a PC-carrying bubble, stall holds, otherwise load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_bd       <= 1'b0;
            r_data     <= {PAY_W{1'b0}};
            r_a3       <= {REG_W{1'b0}};
            r_rd       <= {REG_W{1'b0}};
            r_exc      <= 1'b0;
            r_exc_code <= {EXC_W{1'b0}};
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_pc       <= pc_in;
            r_bd       <= bd_in;
            r_data     <= {PAY_W{1'b0}};
            r_a3       <= {REG_W{1'b0}};
            r_rd       <= {REG_W{1'b0}};
            r_exc      <= 1'b0;
            r_exc_code <= {EXC_W{1'b0}};
        end else if (stall) begin
            r_valid    <= r_valid;
            r_pc       <= r_pc;
            r_bd       <= r_bd;
            r_data     <= r_data;
            r_a3       <= r_a3;
            r_rd       <= r_rd;
            r_exc      <= r_exc;
            r_exc_code <= r_exc_code;
        end else begin
            r_valid    <= valid_in;
            r_pc       <= pc_in;
            r_bd       <= bd_in;
            r_data     <= data_in;
            r_a3       <= w_a3_next;
            r_rd       <= rd_in;
            r_exc      <= w_exc_merged;
            r_exc_code <= w_code_merged;
        end
    end

    // Stall performance counter, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign valid_out    = r_valid;
    assign pc_out       = r_pc;
    assign bd_out       = r_bd;
    assign data_out     = r_data;
    assign a3_out       = r_a3;
    assign rd_out       = r_rd;
    assign exc_out      = r_exc;
    assign exc_code_out = r_exc_code;
    assign stall_cnt    = r_stall_cnt;

endmodule
